// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter
// Merges load and ALU results into the single register-file write stream
// (wb_we / wb_rd / wb_data). When both sources complete in the same cycle,
// the surplus goes into an in-order circular queue. The block then drains
// one write per cycle. A combinational lookup reports to the hazard unit
// any register that has a write still queued or on the output register.
//
// Ports:
//   clk, rst_n           clock and synchronous active-low reset
//   ld_valid/rd/data     load result (older instruction, ordered first)
//   alu_valid/rd/data    ALU result
//   in_ready             both sources may present this cycle
//   wb_we/rd/data        register-file write port (WE3 / AD3 / WD3)
//   q_rs1/q_rs2          hazard query addresses
//   q_hit1/q_hit2        query address has a write queued or on wb_*
//   count                queued entries, excluding the output register
module wb_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ld_valid,
  input  logic [4:0]                   ld_rd,
  input  logic [DATA_WIDTH-1:0]        ld_data,
  input  logic                         alu_valid,
  input  logic [4:0]                   alu_rd,
  input  logic [DATA_WIDTH-1:0]        alu_data,
  output logic                         in_ready,
  output logic                         wb_we,
  output logic [4:0]                   wb_rd,
  output logic [DATA_WIDTH-1:0]        wb_data,
  input  logic [4:0]                   q_rs1,
  input  logic [4:0]                   q_rs2,
  output logic                         q_hit1,
  output logic                         q_hit2,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [4:0]            rd;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t                mem [DEPTH];
  logic [PW-1:0]         rptr_reg, wptr_reg;
  logic [CW-1:0]         count_reg;
  logic                  wb_we_reg;
  logic [4:0]            wb_rd_reg;
  logic [DATA_WIDTH-1:0] wb_data_reg;

  logic                  acc_ld, acc_alu;
  logic [CW-1:0]         n_in;
  entry_t                ld_e, alu_e, out_e, enq0, enq1;
  logic                  out_v, pop, enq0_v, enq1_v;
  logic [CW-1:0]         count_next;
  logic [PW-1:0]         rptr_next, wptr_next;

  assign in_ready = (count_reg != CW'(DEPTH));

  // Writes to x0 are dropped at acceptance and never reach the queue.
  assign acc_ld  = ld_valid  && in_ready && (ld_rd  != 5'd0);
  assign acc_alu = alu_valid && in_ready && (alu_rd != 5'd0);
  assign n_in    = CW'(acc_ld) + CW'(acc_alu);

  assign ld_e  = '{rd: ld_rd,  data: ld_data};
  assign alu_e = '{rd: alu_rd, data: alu_data};

  // Candidate order is queue (oldest first), then load, then ALU. The head
  // candidate goes to the output register and the rest are appended to
  // the queue.
  always_comb begin
    out_v  = 1'b0;
    out_e  = mem[rptr_reg];
    pop    = 1'b0;
    enq0_v = 1'b0;
    enq0   = ld_e;
    enq1_v = 1'b0;
    enq1   = alu_e;
    if (count_reg != '0) begin
      out_v = 1'b1;
      pop   = 1'b1;
      if (acc_ld) begin
        enq0_v = 1'b1;
        enq1_v = acc_alu;
      end else if (acc_alu) begin
        enq0_v = 1'b1;
        enq0   = alu_e;
      end
    end else if (acc_ld) begin
      out_v  = 1'b1;
      out_e  = ld_e;
      enq0_v = acc_alu;
      enq0   = alu_e;
    end else if (acc_alu) begin
      out_v = 1'b1;
      out_e = alu_e;
    end
  end

  // With an empty candidate list, both n_in and count are zero, so this
  // never underflows.
  assign count_next = count_reg + n_in - CW'(out_v);
  assign rptr_next  = rptr_reg + PW'(pop);
  assign wptr_next  = wptr_reg + PW'(enq0_v) + PW'(enq1_v);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rptr_reg    <= '0;
      wptr_reg    <= '0;
      count_reg   <= '0;
      wb_we_reg   <= 1'b0;
      wb_rd_reg   <= '0;
      wb_data_reg <= '0;
    end else begin
      rptr_reg  <= rptr_next;
      wptr_reg  <= wptr_next;
      count_reg <= count_next;
      wb_we_reg <= out_v;
      if (out_v) begin
        wb_rd_reg   <= out_e.rd;
        wb_data_reg <= out_e.data;
      end
    end
  end

  // Queue storage needs no reset because the pointers and count define
  // which slots are live. The two write ports land at wptr and wptr+1.
  always_ff @(posedge clk) begin
    if (enq0_v) mem[wptr_reg] <= enq0;
    if (enq1_v) mem[wptr_reg + PW'(1)] <= enq1;
  end

  // A slot is live when its distance from rptr is below count.
  logic [DEPTH-1:0] hit1_vec, hit2_vec;
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [PW-1:0] offset;
      logic          live;
      assign offset       = PW'(gi) - rptr_reg;
      assign live         = (CW'(offset) < count_reg);
      assign hit1_vec[gi] = live && (mem[gi].rd == q_rs1);
      assign hit2_vec[gi] = live && (mem[gi].rd == q_rs2);
    end
  endgenerate

  // The output register is included because the register file writes it
  // only on the following negedge.
  assign q_hit1 = (q_rs1 != 5'd0) &&
                  ((wb_we_reg && (wb_rd_reg == q_rs1)) || (|hit1_vec));
  assign q_hit2 = (q_rs2 != 5'd0) &&
                  ((wb_we_reg && (wb_rd_reg == q_rs2)) || (|hit2_vec));

  assign wb_we   = wb_we_reg;
  assign wb_rd   = wb_rd_reg;
  assign wb_data = wb_data_reg;
  assign count   = count_reg;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Testbench for wb_write_arbiter. The stimulus process keeps a queue-level
// reference model. Each accepted write is pushed into a scoreboard, and a
// separate monitor pops and compares the scoreboard on every wb_we pulse.
module tb_wb_write_arbiter;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]    rd;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ld_valid = 1'b0, alu_valid = 1'b0;
  logic [4:0]    ld_rd = '0, alu_rd = '0, q_rs1 = '0, q_rs2 = '0;
  logic [DW-1:0] ld_data = '0, alu_data = '0;
  logic          in_ready, wb_we, q_hit1, q_hit2;
  logic [4:0]    wb_rd;
  logic [DW-1:0] wb_data;
  logic [2:0]    count;

  int errors = 0;
  int checks = 0;

  wr_t sb[$];    // accepted writes not yet observed on wb_*
  wr_t pend[$];  // model of queue contents (excludes output register)
  logic       m_out_v = 1'b0;
  logic [4:0] m_out_rd = '0;

  wb_write_arbiter #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .in_ready(in_ready),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .q_hit1(q_hit1), .q_hit2(q_hit2),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_hit(input logic [4:0] rs);
    if (rs == 5'd0) return 1'b0;
    if (m_out_v && m_out_rd == rs) return 1'b1;
    foreach (pend[i]) if (pend[i].rd == rs) return 1'b1;
    return 1'b0;
  endfunction

  // Monitor: every write on wb_* must match the oldest outstanding
  // accepted write.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (wb_we === 1'b1) begin
        wr_t e;
        if (sb.size() == 0) begin
          check("unexpected_write", 32'(wb_rd), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("wb_rd", 32'(wb_rd), 32'(e.rd));
          check("wb_data", wb_data, e.data);
          $display("write rd=%0d data=%08h", wb_rd, wb_data);
        end
      end
    end
  end

  // One cycle: check the state left by the previous posedge, then drive the
  // inputs for the next posedge and advance the model accordingly.
  task automatic cycle(input logic rst, input logic lv, input logic [4:0] lrd,
                       input logic [DW-1:0] ld, input logic av,
                       input logic [4:0] ard, input logic [DW-1:0] ad,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    logic rdy;
    @(negedge clk);
    q_rs1 = rs1;
    q_rs2 = rs2;
    #1;
    check("count", 32'(count), 32'(pend.size()));
    check("in_ready", 32'(in_ready), 32'(pend.size() != DEPTH));
    check("wb_we", 32'(wb_we), 32'(m_out_v));
    check("q_hit1", 32'(q_hit1), 32'(exp_hit(rs1)));
    check("q_hit2", 32'(q_hit2), 32'(exp_hit(rs2)));
    rst_n = rst; ld_valid = lv; ld_rd = lrd; ld_data = ld;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    if (!rst) begin
      pend.delete();
      sb.delete();
      m_out_v = 1'b0;
    end else begin
      rdy = (pend.size() != DEPTH);
      if (rdy && lv && lrd != 0) begin
        pend.push_back('{lrd, ld});
        sb.push_back('{lrd, ld});
      end
      if (rdy && av && ard != 0) begin
        pend.push_back('{ard, ad});
        sb.push_back('{ard, ad});
      end
      if (pend.size() > 0) begin
        wr_t h;
        h = pend.pop_front();
        m_out_v  = 1'b1;
        m_out_rd = h.rd;
      end else begin
        m_out_v = 1'b0;
      end
    end
    $display("cycle rst_n=%0b ld=%0b/%0d alu=%0b/%0d count_exp=%0d",
             rst, lv, lrd, av, ard, pend.size());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Single ALU result
    cycle(1, 0, 0, 0, 1, 5'd5, 32'h0000_00AA, 5'd5, 0);
    idle(2);
    // Simultaneous load and ALU
    cycle(1, 1, 5'd3, 32'h1111, 1, 5'd4, 32'h2222, 5'd3, 5'd4);
    idle(3);
    // rd=0 filter
    cycle(1, 1, 5'd7, 32'h7, 1, 5'd0, 32'hDEAD, 5'd0, 5'd7);
    idle(2);
    // Fill to full, present inputs while full, then drain across the wrap.
    for (int i = 0; i < 5; i++)
      cycle(1, 1, 5'(10 + 2*i), 32'(32'h100 + i), 1, 5'(11 + 2*i), 32'(32'h200 + i),
            5'(10 + 2*i), 5'd21);
    idle(6);
    // Hazard query: output writes rd=2 while rd=9 waits in the queue.
    cycle(1, 1, 5'd2, 32'hA2, 1, 5'd9, 32'hA9, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 5'd9, 5'd2);
    cycle(1, 0, 0, 0, 0, 0, 0, 5'd9, 5'd2);
    cycle(1, 0, 0, 0, 0, 0, 0, 5'd9, 5'd2);
    // Reset mid-drain with count=3.
    for (int i = 0; i < 3; i++)
      cycle(1, 1, 5'(1 + i), 32'(32'h300 + i), 1, 5'(20 + i), 32'(32'h400 + i), 5'd20, 5'd1);
    cycle(0, 0, 0, 0, 0, 0, 0, 5'd21, 5'd22);
    cycle(1, 0, 0, 0, 0, 0, 0, 5'd21, 5'd22);
    idle(4);
    // Randomized traffic, with hazard queries biased toward live registers.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] lr, ar, r1, r2;
      lr = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      ar = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      r1 = (pend.size() > 0 && $urandom_range(0, 1) == 1) ? pend[pend.size()-1].rd
                                                          : 5'($urandom_range(0, 31));
      r2 = m_out_v ? m_out_rd : 5'($urandom_range(0, 31));
      cycle(1, ($urandom_range(0, 99) < 60), lr, $urandom,
               ($urandom_range(0, 99) < 60), ar, $urandom, r1, r2);
    end
    idle(8);
    #2;
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
